key_seq_reader: RTL and testbench

- Bus-master front end for the serial key sequencer PAL.
- Accepts a read command, generates qualified read cycles into the sequencer window (BA13=0, BA12=1, BR_W=1, SSER strobed low, BA7..BA4 = code), and samples the SDRD bit at the end of each strobe.
- Assembles up to 16 returned bits into a word and hands it to the host over a valid/ready response channel.
- Sits directly upstream of the sequencer, which advances its state on each qualified clocked access, and directly downstream of it for the SDRD data.

---
 rtl/key_seq_reader.sv | 150 +++++++++++++++
 tb/tb_key_seq_reader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_seq_reader.sv
// Bus-master front end for the serial key sequencer: issues qualified read strobes,
// shifts in SDRD bits and returns the assembled word over a valid/ready channel.
module key_seq_reader #(
   parameter int unsigned ACC_CYCLES = 3,
   parameter int unsigned GAP_CYCLES = 1,
   parameter int unsigned MAXBITS    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [3:0]         cmd_code,
   input  logic [4:0]         cmd_len,
   input  logic               abort,
   input  logic               sdrd,
   output logic               ba13,
   output logic               ba12,
   output logic [3:0]         ba7_4,
   output logic               sser_n,
   output logic               br_w,
   output logic               busy,
   output logic               rsp_valid,
   output logic [MAXBITS-1:0] rsp_data,
   input  logic               rsp_ready
);

   localparam int unsigned CNT_W  = $clog2(MAXBITS + 1);
   localparam int unsigned MAX_PH = (ACC_CYCLES > GAP_CYCLES) ? ACC_CYCLES : GAP_CYCLES;
   localparam int unsigned PH_W   = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      GAP    = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   len_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [PH_W-1:0]    ph_q;
   logic [MAXBITS-1:0] shreg;
   logic [CNT_W-1:0]   eff_len_c;

   // A length of zero or beyond the word width reads a full word.
   always_comb begin
      eff_len_c = CNT_W'(MAXBITS);
      if (cmd_len != 5'd0 && 32'(cmd_len) <= 32'(MAXBITS))
         eff_len_c = CNT_W'(cmd_len);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         len_q     <= '0;
         cnt_q     <= '0;
         ph_q      <= '0;
         shreg     <= '0;
         ba13      <= 1'b1;
         ba12      <= 1'b0;
         ba7_4     <= 4'd0;
         sser_n    <= 1'b1;
         br_w      <= 1'b0;
         busy      <= 1'b0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else if (abort && state != IDLE) begin
         // Abort deselects the window at once and drops any partial or pending word.
         state     <= IDLE;
         ph_q      <= '0;
         ba13      <= 1'b1;
         ba12      <= 1'b0;
         ba7_4     <= 4'd0;
         sser_n    <= 1'b1;
         br_w      <= 1'b0;
         busy      <= 1'b0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid && !abort) begin
                  len_q     <= eff_len_c;
                  cnt_q     <= '0;
                  ph_q      <= '0;
                  shreg     <= '0;
                  ba13      <= 1'b0;
                  ba12      <= 1'b1;
                  br_w      <= 1'b1;
                  ba7_4     <= cmd_code;
                  sser_n    <= 1'b1;
                  busy      <= 1'b1;
                  cmd_ready <= 1'b0;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               sser_n <= 1'b0;
               ph_q   <= '0;
               state  <= STROBE;
            end
            STROBE: begin
               if (ph_q == PH_W'(ACC_CYCLES - 1)) begin
                  shreg  <= {shreg[MAXBITS-2:0], sdrd};
                  cnt_q  <= cnt_q + CNT_W'(1);
                  sser_n <= 1'b1;
                  ph_q   <= '0;
                  state  <= GAP;
               end else begin
                  ph_q <= ph_q + PH_W'(1);
               end
            end
            GAP: begin
               if (ph_q == PH_W'(GAP_CYCLES - 1)) begin
                  ph_q <= '0;
                  if (cnt_q < len_q) begin
                     state <= SETUP;
                  end else begin
                     ba13     <= 1'b1;
                     ba12     <= 1'b0;
                     ba7_4    <= 4'd0;
                     br_w     <= 1'b0;
                     rsp_data <= shreg;
                     state    <= DONE;
                  end
               end else begin
                  ph_q <= ph_q + PH_W'(1);
               end
            end
            DONE: begin
               // Word is presented one clock after the bus is released.
               if (!rsp_valid) begin
                  rsp_valid <= 1'b1;
               end else if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_seq_reader.sv
// Self-checking bench for key_seq_reader: vector table, corner sequences,
// random commands against a word-level reference, and a strobe-qualification monitor.
module tb_key_seq_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_code = 4'd0;
   logic [4:0]  cmd_len = 5'd0;
   logic        abort = 1'b0;
   logic        sdrd;
   logic        ba13, ba12, sser_n, br_w, busy, rsp_valid;
   logic [3:0]  ba7_4;
   logic [15:0] rsp_data;
   logic        rsp_ready = 1'b0;

   always #5 clk = ~clk;

   key_seq_reader #(.ACC_CYCLES(3), .GAP_CYCLES(1), .MAXBITS(16)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_code(cmd_code), .cmd_len(cmd_len), .abort(abort), .sdrd(sdrd),
      .ba13(ba13), .ba12(ba12), .ba7_4(ba7_4), .sser_n(sser_n), .br_w(br_w),
      .busy(busy), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
   );

   int compared = 0;
   int mism = 0;

   // Sequencer side: one source bit per completed strobe, pull-up beyond the pattern.
   int          strobe_cnt = 0;
   int          base = 0;
   int          low_len = 0;
   logic        prev_q = 1'b0;
   logic [3:0]  exp_code = 4'd0;
   logic [63:0] src_bits = '1;
   assign sdrd = src_bits[6'(strobe_cnt - base)];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mism++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Strobe monitor: width, code and address qualification one clock ahead.
   always @(negedge clk) begin
      if (!rst_n) begin
         low_len = 0;
         prev_q  = 1'b0;
      end else begin
         if (!sser_n) begin
            low_len++;
            if (!(prev_q && !ba13 && ba12 && br_w) || ba7_4 !== exp_code) begin
               compared++;
               mism++;
               $display("FAIL strobe_qual: ba13=%b ba12=%b br_w=%b prev_q=%b ba7_4=%h expected code %h",
                        ba13, ba12, br_w, prev_q, ba7_4, exp_code);
            end
         end else if (low_len != 0) begin
            strobe_cnt++;
            compared++;
            if (low_len != 3) begin
               mism++;
               $display("FAIL strobe_width: got %0d expected 3", low_len);
            end
            low_len = 0;
         end
         prev_q = !ba13 && ba12 && br_w;
      end
   end

   function automatic int eff_len(input logic [4:0] len);
      return (len == 5'd0 || len > 5'd16) ? 16 : int'(len);
   endfunction

   // First bit returned is the most significant of an L-bit number.
   function automatic logic [15:0] ref_word(input logic [15:0] pat, input int len);
      int unsigned acc = 0;
      for (int i = 0; i < len; i++)
         if (pat[i]) acc += 32'd1 << (len - 1 - i);
      return 16'(acc);
   endfunction

   // Issue one command from IDLE, check timing and word, apply backpressure, handshake.
   task automatic run_cmd(input logic [3:0] code, input logic [4:0] len, input logic [15:0] pat,
                          input int hold, input logic [15:0] exp_data, input int exp_lat);
      int lat;
      int nstr;
      logic [15:0] snap;
      src_bits  = {48'hFFFF_FFFF_FFFF, pat};
      exp_code  = code;
      base      = strobe_cnt;
      cmd_code  = code;
      cmd_len   = len;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("accept_busy", 32'(busy), 32'd1);
      check("accept_cmd_ready", 32'(cmd_ready), 32'd0);
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check("rsp_latency", 32'(lat), 32'(exp_lat));
      check("rsp_data", 32'(rsp_data), 32'(exp_data));
      nstr = strobe_cnt - base;
      check("strobe_count", 32'(nstr), 32'((exp_lat - 1) / 5));
      check("done_bus_ba13", 32'(ba13), 32'd1);
      snap = rsp_data;
      for (int h = 0; h < hold; h++) begin
         cmd_valid = (h % 3 == 1);
         @(posedge clk); #1;
         check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
         check("hold_rsp_data", 32'(rsp_data), 32'(snap));
         check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      cmd_valid = 1'b0;
      if (hold > 0) check("hold_no_strobes", 32'(strobe_cnt - base), 32'(nstr));
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("hs_rsp_valid", 32'(rsp_valid), 32'd0);
      check("hs_cmd_ready", 32'(cmd_ready), 32'd1);
      check("hs_busy", 32'(busy), 32'd0);
   endtask

   typedef struct {
      logic [3:0]  code;
      logic [4:0]  len;
      logic [15:0] pat;
      int          hold;
      logic [15:0] exp_data;
      int          exp_lat;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #4_000_000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", compared, mism);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int seen;
      logic [7:0] pal;
      logic [3:0] pcodes[4];
      int plens[4];

      vecs[0] = '{4'h2, 5'd4,  16'h000D, 10, 16'h000B, 21};
      vecs[1] = '{4'h0, 5'd0,  16'hFFFF, 0,  16'hFFFF, 81};
      vecs[2] = '{4'h1, 5'd20, 16'hFFFF, 2,  16'hFFFF, 81};
      vecs[3] = '{4'h5, 5'd1,  16'h0000, 0,  16'h0000, 6};
      vecs[4] = '{4'hF, 5'd16, 16'h0001, 1,  16'h8000, 81};
      vecs[5] = '{4'h7, 5'd8,  16'h00F0, 0,  16'h000F, 41};
      vecs[6] = '{4'hA, 5'd17, 16'h5555, 0,  16'hAAAA, 81};

      // Reset values while held and after release.
      repeat (3) @(posedge clk);
      #1;
      check("rst_sser_n", 32'(sser_n), 32'd1);
      check("rst_ba13", 32'(ba13), 32'd1);
      check("rst_ba12", 32'(ba12), 32'd0);
      check("rst_br_w", 32'(br_w), 32'd0);
      check("rst_ba7_4", 32'(ba7_4), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

      for (int i = 0; i < 7; i++)
         run_cmd(vecs[i].code, vecs[i].len, vecs[i].pat, vecs[i].hold,
                 vecs[i].exp_data, vecs[i].exp_lat);

      // Abort during the gap after bit 3 of an 8-bit read.
      src_bits  = '1;
      exp_code  = 4'h6;
      base      = strobe_cnt;
      cmd_code  = 4'h6;
      cmd_len   = 5'd8;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_sser_n", 32'(sser_n), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
      check("abort_ba13", 32'(ba13), 32'd1);
      check("abort_strobes", 32'(strobe_cnt - base), 32'd3);
      seen = 0;
      repeat (60) begin
         @(posedge clk); #1;
         if (rsp_valid) seen++;
      end
      check("abort_no_rsp", 32'(seen), 32'd0);
      check("abort_no_more_strobes", 32'(strobe_cnt - base), 32'd3);
      run_cmd(4'h1, 5'd1, 16'h0001, 0, 16'h0001, 6);

      // Abort while the response is pending.
      src_bits  = '1;
      exp_code  = 4'h3;
      base      = strobe_cnt;
      cmd_code  = 4'h3;
      cmd_len   = 5'd2;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check("done_abort_lat", 32'(lat), 32'd11);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("done_abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check("done_abort_cmd_ready", 32'(cmd_ready), 32'd1);

      // Abort in IDLE wins over a simultaneous command.
      base      = strobe_cnt;
      cmd_valid = 1'b1;
      abort     = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      abort     = 1'b0;
      check("idle_abort_busy", 32'(busy), 32'd0);
      check("idle_abort_cmd_ready", 32'(cmd_ready), 32'd1);
      repeat (10) @(posedge clk);
      #1;
      check("idle_abort_no_strobes", 32'(strobe_cnt - base), 32'd0);

      // Reset in the middle of a strobe.
      exp_code  = 4'h9;
      base      = strobe_cnt;
      cmd_code  = 4'h9;
      cmd_len   = 5'd4;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = 0;
      while (sser_n !== 1'b0 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("pre_rst_sser_low", 32'(sser_n), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_sser_n", 32'(sser_n), 32'd1);
      check("async_rst_ba13", 32'(ba13), 32'd1);
      check("async_rst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst2_cmd_ready", 32'(cmd_ready), 32'd1);
      check("post_rst2_busy", 32'(busy), 32'd0);

      // Sequencer stepped through codes 9..C; each access advances its state.
      pcodes = '{4'h9, 4'hA, 4'hB, 4'hC};
      plens  = '{3, 5, 4, 6};
      pal = 8'h5A;
      for (int c = 0; c < 4; c++) begin
         logic [15:0] pat;
         pat = '0;
         for (int i = 0; i < plens[c]; i++) begin
            pal = 8'(pal * 8'd5 + 8'(pcodes[c]) + 8'd1);
            pat[i] = pal[7];
         end
         run_cmd(pcodes[c], 5'(plens[c]), pat, 0, ref_word(pat, plens[c]), 5 * plens[c] + 1);
      end

      // Random commands against the word-level reference.
      for (int n = 0; n < 30; n++) begin
         logic [3:0]  rc;
         logic [4:0]  rl;
         logic [15:0] rp;
         int          el;
         rc = 4'($urandom);
         rl = 5'($urandom);
         rp = 16'($urandom);
         el = eff_len(rl);
         run_cmd(rc, rl, rp, int'($urandom_range(0, 3)), ref_word(rp, el), 5 * el + 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end

endmodule
